zero_run_monitor: RTL
=====================

# zero_run_monitor

Loss-of-signal monitor for the gain control loop. It sits directly downstream of the single-bit zero detector and consumes its per-sample "sample is zero" flag. It tracks consecutive all-zero samples and declares signal loss after a programmable run length. It declares recovery after a run of non-zero samples and reports the current and longest zero-run lengths to the loop controller.

## Interface
Parameters:
- CNT_WIDTH, 8: width of the run-length counters.
- LOSS_THR, 16: consecutive zero samples that declare loss; legal range 2 .. 2^CNT_WIDTH-1.
- RECOV_THR, 4: consecutive non-zero samples that declare recovery; legal range 2 .. 2^CNT_WIDTH-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  qualifies zero_in; the block advances only on cycles with valid=1.
- zero_in  in  1  zero-detector output; 1 = current sample is all zeros.
- clr_max  in  1  clears max_run.
- lost  out  1  level; signal declared lost.
- lost_evt  out  1  one-cycle pulse on entry to lost.
- recov_evt  out  1  one-cycle pulse on exit from lost.
- zrun_len  out  CNT_WIDTH  length of the current zero run, saturating.
- max_run  out  CNT_WIDTH  longest zero run since reset or clr_max, saturating.

## Operation
- Reset values: FSM = ACTIVE, internal counter cnt = 0, lost = 0, lost_evt = 0, recov_evt = 0, zrun_len = 0, max_run = 0.
- Inputs are ignored when valid=0: state, counters and levels hold, and both pulses are 0.
- FSM transitions on valid samples:
  - ACTIVE, zero_in=1: go to ZRUN, cnt=1.
  - ACTIVE, zero_in=0: stay in ACTIVE.
  - ZRUN, zero_in=1: cnt+1. If cnt+1 == LOSS_THR, go to LOST, lost=1, lost_evt=1, cnt=0.
  - ZRUN, zero_in=0: go to ACTIVE, cnt=0.
  - LOST, zero_in=1: stay in LOST.
  - LOST, zero_in=0: go to RECOV, cnt=1.
  - RECOV, zero_in=0: cnt+1. If cnt+1 == RECOV_THR, go to ACTIVE, lost=0, recov_evt=1, cnt=0.
  - RECOV, zero_in=1: go back to LOST, cnt=0, no pulse.
- zrun_len, independent of the FSM:
  - A valid zero sample increments it; it saturates at 2^CNT_WIDTH-1 and never wraps.
  - A valid non-zero sample clears it to 0.
- max_run:
  - On each valid zero sample, max_run takes the maximum of itself and the new zrun_len.
  - clr_max has priority over the update: max_run=0 that cycle, even if a valid zero sample is present.
- Arithmetic is unsigned. Comparisons against LOSS_THR and RECOV_THR use cnt+1 computed at CNT_WIDTH+1 bits, so there is no overflow aliasing.

## Timing
- All outputs are registered. Latency is 1 cycle from the valid sample edge to the output change.
- lost rises in the cycle after the LOSS_THR-th consecutive valid zero sample. lost_evt is high in that same cycle only.
- recov_evt and the fall of lost occur in the cycle after the completing valid non-zero sample.
- Gaps with valid=0 do not break a run. Only valid samples count.
- rst asserted mid-run (any state) returns everything to reset values on the next edge. rst overrides valid and clr_max.

## Configuration
- Macro: ZERO_RUN_RECOV_HYST_EN.
- Defined: recovery hysteresis as described above (RECOV state, RECOV_THR samples).
- Undefined: the RECOV state and RECOV_THR comparison are not built. A single valid non-zero sample in LOST goes straight to ACTIVE with lost=0 and recov_evt=1. RECOV_THR is ignored.

## Test plan
- Reset, then 15 valid zero samples with LOSS_THR=16 -> lost=0, zrun_len=15. The 16th sample -> next cycle lost=1, lost_evt=1 for exactly 1 cycle.
- Same stream of 16 zero samples with valid=0 gaps of 3 cycles between samples -> lost asserts only after the 16th valid sample; outputs hold during the gaps.
- In LOST: 3 non-zero samples, then 1 zero, then 4 non-zero (RECOV_THR=4, macro defined) -> lost stays 1 after the first 3 non-zero samples and the zero; it falls after the 4th of the final 4, with a single recov_evt. Macro undefined -> lost falls after the first non-zero sample.
- CNT_WIDTH=4 with 20 consecutive zero samples -> zrun_len and max_run saturate at 15. One non-zero sample -> zrun_len=0, max_run=15. Then clr_max together with a valid zero sample -> max_run=0.
- rst pulsed in the middle of a ZRUN at cnt=10 -> all outputs 0. The next 15 zero samples do not assert lost; the 16th does.

Source files
------------

// File: rtl/zero_run_monitor.sv
// Loss-of-signal monitor: counts consecutive valid zero samples, declares loss/recovery, reports run lengths.
// Optional macro ZERO_RUN_RECOV_HYST_EN builds the RECOV hysteresis state; undefined, one non-zero sample recovers.
module zero_run_monitor #(
  parameter int CNT_WIDTH = 8,
  parameter int LOSS_THR  = 16,
  parameter int RECOV_THR = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 zero_in,
  input  logic                 clr_max,
  output logic                 lost,
  output logic                 lost_evt,
  output logic                 recov_evt,
  output logic [CNT_WIDTH-1:0] zrun_len,
  output logic [CNT_WIDTH-1:0] max_run
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_ZRUN   = 2'd1,
    ST_LOST   = 2'd2,
    ST_RECOV  = 2'd3
  } state_t;

  if (LOSS_THR < 2 || LOSS_THR > (2 ** CNT_WIDTH) - 1) begin : g_bad_loss_thr
    $error("zero_run_monitor: LOSS_THR out of range");
  end
  if (RECOV_THR < 2 || RECOV_THR > (2 ** CNT_WIDTH) - 1) begin : g_bad_recov_thr
    $error("zero_run_monitor: RECOV_THR out of range");
  end

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH:0]   LOSS_THR_W = (CNT_WIDTH + 1)'(LOSS_THR);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lost_q, lost_d;
  logic                 lost_evt_q, lost_evt_d;
  logic                 recov_evt_q, recov_evt_d;
  logic [CNT_WIDTH-1:0] zrun_q, zrun_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH:0]   cnt_inc;

  // One extra bit so a threshold of 2^CNT_WIDTH-1 never aliases with a wrapped count.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    lost_evt_d  = 1'b0;
    recov_evt_d = 1'b0;
    if (valid) begin
      case (state_q)
        ST_ACTIVE: begin
          if (zero_in) begin
            state_d = ST_ZRUN;
            cnt_d   = ONE;
          end
        end
        ST_ZRUN: begin
          if (!zero_in) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else if (cnt_inc == LOSS_THR_W) begin
            state_d    = ST_LOST;
            lost_d     = 1'b1;
            lost_evt_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc[CNT_WIDTH-1:0];
          end
        end
        ST_LOST: begin
          if (!zero_in) begin
`ifdef ZERO_RUN_RECOV_HYST_EN
            state_d = ST_RECOV;
            cnt_d   = ONE;
`else
            state_d     = ST_ACTIVE;
            lost_d      = 1'b0;
            recov_evt_d = 1'b1;
            cnt_d       = '0;
`endif
          end
        end
`ifdef ZERO_RUN_RECOV_HYST_EN
        ST_RECOV: begin
          if (zero_in) begin
            state_d = ST_LOST;
            cnt_d   = '0;
          end else if (cnt_inc == (CNT_WIDTH + 1)'(RECOV_THR)) begin
            state_d     = ST_ACTIVE;
            lost_d      = 1'b0;
            recov_evt_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc[CNT_WIDTH-1:0];
          end
        end
`endif
        default: begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Run-length tracking is independent of the FSM; clr_max wins over the max update.
  always_comb begin
    zrun_d = zrun_q;
    max_d  = max_q;
    if (valid) begin
      if (zero_in) begin
        zrun_d = (zrun_q == CNT_MAX) ? zrun_q : zrun_q + ONE;
        if (zrun_d > max_q) max_d = zrun_d;
      end else begin
        zrun_d = '0;
      end
    end
    if (clr_max) max_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACTIVE;
      cnt_q       <= '0;
      lost_q      <= 1'b0;
      lost_evt_q  <= 1'b0;
      recov_evt_q <= 1'b0;
      zrun_q      <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      lost_evt_q  <= lost_evt_d;
      recov_evt_q <= recov_evt_d;
      zrun_q      <= zrun_d;
      max_q       <= max_d;
    end
  end

  assign lost      = lost_q;
  assign lost_evt  = lost_evt_q;
  assign recov_evt = recov_evt_q;
  assign zrun_len  = zrun_q;
  assign max_run   = max_q;

endmodule
